// File: rtl/tff_bank_counter.sv
// tff_bank_counter: WIDTH-bit register that works either as a bank of
// independent T flip-flops or as a modulo-MODULUS up/down counter.
// It also has a synchronous load, a terminal-count flag and a one-cycle
// wrap pulse.
// Optional feature macro: TFF_GRAY_OUT_EN adds a registered q_gray output,
// which always equals q ^ (q >> 1).
module tff_bank_counter #(
    parameter int WIDTH     = 8,
    parameter int MODULUS   = 256,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
`ifdef TFF_GRAY_OUT_EN
    output logic [WIDTH-1:0] q_gray,
`endif
    output logic             tc,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    // Highest legal count. MODULUS may equal 2**WIDTH, so the value is
    // computed in int and then truncated to WIDTH bits.
    localparam logic [WIDTH-1:0] TOP      = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q    = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO     = '0;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic [WIDTH-1:0] toggled;

    // Per-bit T flip-flop: each bit flips when its mask bit is set.
    // No modulus clamp is applied in toggle mode.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tff
            assign toggled[gi] = q_reg[gi] ^ t[gi];
        end
    endgenerate

    // Next-state selection. Load has priority over the enable, and the
    // enable has priority over holding the current value.
    always_comb begin
        q_next    = q_reg;
        wrap_next = 1'b0;
        if (load) begin
            q_next = (load_val > TOP) ? TOP : load_val;
        end else if (en) begin
            case (mode)
                MODE_TOGGLE: q_next = toggled;
                MODE_UP: begin
                    // Values above TOP, which toggle mode can leave behind,
                    // also wrap to zero.
                    if (q_reg >= TOP) begin
                        q_next    = ZERO;
                        wrap_next = 1'b1;
                    end else begin
                        q_next = q_reg + ONE;
                    end
                end
                MODE_DOWN: begin
                    if (q_reg == ZERO) begin
                        q_next    = TOP;
                        wrap_next = 1'b1;
                    end else if (q_reg > TOP) begin
                        // An out-of-range value is pulled back into range.
                        // This does not count as a wrap.
                        q_next = TOP;
                    end else begin
                        q_next = q_reg - ONE;
                    end
                end
                default: q_next = q_reg;
            endcase
        end
    end

    // State register with an asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg    <= RST_Q;
            wrap_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
        end
    end

`ifdef TFF_GRAY_OUT_EN
    logic [WIDTH-1:0] q_gray_reg;

    // Gray-coded copy of q. It is registered from q_next, so it changes
    // on the same edge as q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_gray_reg <= RST_Q ^ (RST_Q >> 1);
        end else begin
            q_gray_reg <= q_next ^ (q_next >> 1);
        end
    end

    assign q_gray = q_gray_reg;
`endif

    // Terminal count depends only on the current value and the mode.
    // It does not depend on en.
    always_comb begin
        tc = 1'b0;
        if (mode == MODE_UP)
            tc = (q_reg == TOP);
        else if (mode == MODE_DOWN)
            tc = (q_reg == ZERO);
    end

    assign q    = q_reg;
    assign wrap = wrap_reg;

endmodule

// File: tb/tb_tff_bank_counter.sv
// Testbench for tff_bank_counter with WIDTH=8, MODULUS=10.
// Directed scenarios first, then randomized cycles.
// Every cycle is checked against a behavioural model.
module tb_tff_bank_counter;

    localparam int W   = 8;
    localparam int MOD = 10;
    localparam int RV  = 0;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] t;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;
`ifdef TFF_GRAY_OUT_EN
    logic [W-1:0] q_gray;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model state: current value and pending wrap pulse.
    int m_q;
    int m_wrap;

    always #5 clk = ~clk;

    tff_bank_counter #(.WIDTH(W), .MODULUS(MOD), .RESET_VAL(RV)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .t        (t),
        .load     (load),
        .load_val (load_val),
        .q        (q),
`ifdef TFF_GRAY_OUT_EN
        .q_gray   (q_gray),
`endif
        .tc       (tc),
        .wrap     (wrap)
    );

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int model_tc(input int val, input logic [1:0] md);
        if (md == 2'b01) return (val == MOD - 1) ? 1 : 0;
        if (md == 2'b10) return (val == 0) ? 1 : 0;
        return 0;
    endfunction

    // Check q, wrap, tc and (if present) q_gray against the model.
    task automatic check_outputs(input string tag);
        check_value({tag, ".q"}, 32'(q), 32'(m_q));
        check_value({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
        check_value({tag, ".tc"}, 32'(tc), 32'(model_tc(m_q, mode)));
`ifdef TFF_GRAY_OUT_EN
        check_value({tag, ".gray"}, 32'(q_gray), 32'(m_q ^ (m_q >> 1)));
`endif
    endtask

    // Apply one cycle of inputs. The inputs are driven 1 time unit after
    // an edge. The model advances and the outputs are checked 1 time unit
    // after the next edge.
    task automatic step(input string tag, input logic l, input int lv, input logic e,
                        input logic [1:0] md, input int tt);
        load     = l;
        load_val = W'(lv);
        en       = e;
        mode     = md;
        t        = W'(tt);
        #1;
        check_value({tag, ".tc_pre"}, 32'(tc), 32'(model_tc(m_q, md)));
        @(posedge clk);
        #1;
        m_wrap = 0;
        if (l) begin
            m_q = (lv > MOD - 1) ? MOD - 1 : lv;
        end else if (e) begin
            if (md == 2'b00) begin
                m_q = (m_q ^ tt) % (1 << W);
            end else if (md == 2'b01) begin
                if (m_q >= MOD - 1) begin m_q = 0; m_wrap = 1; end
                else m_q = m_q + 1;
            end else if (md == 2'b10) begin
                if (m_q == 0) begin m_q = MOD - 1; m_wrap = 1; end
                else if (m_q > MOD - 1) m_q = MOD - 1;
                else m_q = m_q - 1;
            end
        end
        check_outputs(tag);
        $display("%-10s load=%0d lv=%0d en=%0d mode=%0d t=%02h -> q=%02h wrap=%0d tc=%0d",
                 tag, l, lv, e, md, tt[7:0], q, wrap, tc);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 2'b11; t = '0; load = 1'b0; load_val = '0;
        m_q = RV; m_wrap = 0;
        #12;
        check_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Scenario 1: count up, then reset asynchronously while q is 6.
        for (int i = 0; i < 6; i++) step("up_run", 0, 0, 1, 2'b01, 0);
        check_value("pre_reset.q", 32'(q), 32'd6);
        #2 reset = 1'b1;
        #1;
        m_q = 0; m_wrap = 0;
        check_outputs("async_rst");
        #2 reset = 1'b0;
        step("post_rst", 0, 0, 1, 2'b01, 0);
        step("post_rst", 0, 0, 1, 2'b01, 0);

        // Scenario 2: count up through the wrap at MODULUS-1.
        step("load8", 1, 8, 0, 2'b01, 0);
        step("up_wrap", 0, 0, 1, 2'b01, 0);
        step("up_wrap", 0, 0, 1, 2'b01, 0);
        step("up_wrap", 0, 0, 1, 2'b01, 0);

        // Scenario 3: count down through zero, then recover an
        // out-of-range value.
        step("load0", 1, 0, 0, 2'b10, 0);
        step("dn_wrap", 0, 0, 1, 2'b10, 0);
        step("tog_f0", 0, 0, 1, 2'b00, 'hF0);
        check_value("oor.q", 32'(q), 32'hF9);
        step("dn_oor", 0, 0, 1, 2'b10, 0);
        step("up_oor", 1, 0, 0, 2'b01, 0);
        step("up_oor", 0, 0, 1, 2'b00, 'hF0);
        step("up_oor", 0, 0, 1, 2'b01, 0);

        // Scenario 4: load takes priority over the enable; load_val is
        // clamped to MODULUS-1.
        step("load_pri", 1, 3, 1, 2'b01, 0);
        step("load_clp", 1, 200, 1, 2'b10, 0);

        // Scenario 5: toggle bank, then hold with en=0.
        step("load0", 1, 0, 0, 2'b00, 0);
        step("tog_a5", 0, 0, 1, 2'b00, 'hA5);
        step("tog_ff", 0, 0, 1, 2'b00, 'hFF);
        check_value("tog.q", 32'(q), 32'h5A);
        step("hold_en0", 0, 0, 0, 2'b00, 'hFF);
        step("hold_mode", 0, 0, 1, 2'b11, 'hFF);

        // Scenario 6: full up sweep over 0..9. With the macro defined,
        // q_gray is also checked on every step.
        step("load0", 1, 0, 0, 2'b01, 0);
        for (int i = 0; i < 10; i++) step("sweep", 0, 0, 1, 2'b01, 0);

        // Randomized cycles.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
